// File: rtl/matrix_slice_streamer_pkg.sv
// rtl/matrix_slice_streamer_pkg.sv - mode encodings, FSM states and row-major slice offsets for the slice streamer
package matrix_slice_streamer_pkg;

    localparam logic [1:0] SEL_MODE_ROW  = 2'd0;
    localparam logic [1:0] SEL_MODE_COL  = 2'd1;
    localparam logic [1:0] SEL_MODE_ELEM = 2'd2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // LSB of element (i,j) in a row-major flat vector with (0,0) in the MSBs
    function automatic int elem_lsb(int m, int n, int bits, int i, int j);
        return bits * (m * n - n * i - j - 1);
    endfunction

endpackage

// File: rtl/matrix_slice_streamer_mux.sv
// rtl/matrix_slice_streamer_mux.sv - combinational element selector; out-of-range positions read as zero
module matrix_element_mux
    import matrix_slice_streamer_pkg::*;
#(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int nBits = 32,
    parameter int IDX_W = 8
) (
    input  logic [nBits*M*N-1:0] matrix,
    input  logic [IDX_W-1:0]     i,
    input  logic [IDX_W-1:0]     j,
    output logic [nBits-1:0]     element,
    output logic                 in_range
);

    always_comb begin
        element  = '0;
        in_range = (i < IDX_W'(M)) && (j < IDX_W'(N));
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                if (i == IDX_W'(r) && j == IDX_W'(c)) begin
                    element = matrix[elem_lsb(M, N, nBits, r, c) +: nBits];
                end
            end
        end
    end

endmodule

// File: rtl/matrix_slice_streamer.sv
// rtl/matrix_slice_streamer.sv - latched matrix store streaming a row, column or element per request
// SEL_BOUNDS_CHECK_EN: drop out-of-range requests and pulse err instead of streaming zeros
module matrix_slice_streamer
    import matrix_slice_streamer_pkg::*;
#(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int nBits = 32,
    parameter int IDX_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [nBits*M*N-1:0] matrix_in,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_mode,
    input  logic [IDX_W-1:0]     req_i,
    input  logic [IDX_W-1:0]     req_j,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [nBits-1:0]     out_data,
    output logic [IDX_W-1:0]     out_i,
    output logic [IDX_W-1:0]     out_j,
    output logic                 out_last,
`ifdef SEL_BOUNDS_CHECK_EN
    output logic                 err,
`endif
    output logic                 busy
);

    state_t                 state_q;
    logic                   loaded_q;
    logic [nBits*M*N-1:0]   mat_q;
    logic [1:0]             mode_q, mode_d;
    logic [IDX_W-1:0]       ri_q, ri_d, rj_q, rj_d, pos_q, pos_d;
    logic                   out_valid_q, out_last_q;
    logic [nBits-1:0]       out_data_q;
    logic [IDX_W-1:0]       out_i_q, out_j_q;
    logic [IDX_W-1:0]       sel_i, sel_j;
    logic                   last_d, accept_ok, in_range;
    logic [nBits-1:0]       elem;
    logic                   req_fire, beat_fire;
`ifdef SEL_BOUNDS_CHECK_EN
    logic                   err_q;
    assign err = err_q;
`endif

    assign load_ready = (state_q == ST_IDLE);
    assign req_ready  = (state_q == ST_IDLE) && loaded_q && !load_valid;
    assign req_fire   = req_valid && req_ready;
    assign beat_fire  = out_valid_q && out_ready;
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_i      = out_i_q;
    assign out_j      = out_j_q;
    assign out_last   = out_last_q;

    // One mux serves both the first beat (from live request fields) and every later beat
    always_comb begin
        mode_d = req_fire ? req_mode : mode_q;
        ri_d   = req_fire ? req_i    : ri_q;
        rj_d   = req_fire ? req_j    : rj_q;
        pos_d  = req_fire ? '0       : pos_q + 1'b1;
        case (mode_d)
            SEL_MODE_ROW: begin
                sel_i  = ri_d;
                sel_j  = pos_d;
                last_d = (pos_d == IDX_W'(N - 1));
            end
            SEL_MODE_COL: begin
                sel_i  = pos_d;
                sel_j  = rj_d;
                last_d = (pos_d == IDX_W'(M - 1));
            end
            default: begin
                sel_i  = ri_d;
                sel_j  = rj_d;
                last_d = 1'b1;
            end
        endcase
    end

`ifdef SEL_BOUNDS_CHECK_EN
    assign accept_ok = in_range;
`else
    // Without the check every accepted request streams its full beat count
    assign accept_ok = in_range | 1'b1;
`endif

    matrix_element_mux #(.M(M), .N(N), .nBits(nBits), .IDX_W(IDX_W)) u_mux (
        .matrix   (mat_q),
        .i        (sel_i),
        .j        (sel_j),
        .element  (elem),
        .in_range (in_range)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            loaded_q    <= 1'b0;
            mat_q       <= '0;
            mode_q      <= '0;
            ri_q        <= '0;
            rj_q        <= '0;
            pos_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_i_q     <= '0;
            out_j_q     <= '0;
`ifdef SEL_BOUNDS_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
`ifdef SEL_BOUNDS_CHECK_EN
            err_q <= req_fire && !accept_ok;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        mat_q    <= matrix_in;
                        loaded_q <= 1'b1;
                    end else if (req_fire) begin
                        mode_q <= req_mode;
                        ri_q   <= req_i;
                        rj_q   <= req_j;
                        if (accept_ok) begin
                            state_q     <= ST_STREAM;
                            pos_q       <= pos_d;
                            out_valid_q <= 1'b1;
                            out_data_q  <= elem;
                            out_i_q     <= sel_i;
                            out_j_q     <= sel_j;
                            out_last_q  <= last_d;
                        end
                    end
                end
                ST_STREAM: begin
                    if (beat_fire) begin
                        if (out_last_q) begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            pos_q      <= pos_d;
                            out_data_q <= elem;
                            out_i_q    <= sel_i;
                            out_j_q    <= sel_j;
                            out_last_q <= last_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_slice_streamer.sv
// tb/tb_matrix_slice_streamer.sv - scoreboard bench for matrix_slice_streamer
module tb_matrix_slice_streamer;

    localparam int M = 4, N = 4, W = 32, IW = 8;

    typedef struct {
        logic [W-1:0]  d;
        logic [IW-1:0] i;
        logic [IW-1:0] j;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [W*M*N-1:0] matrix_in = '0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_mode = 2'd0;
    logic [IW-1:0]    req_i = '0;
    logic [IW-1:0]    req_j = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_data;
    logic [IW-1:0]    out_i, out_j;
    logic             out_last;
    logic             busy;
`ifdef SEL_BOUNDS_CHECK_EN
    logic             err;
`endif

    int        n_tests = 0;
    int        n_fail  = 0;
    int        rdy_mode = 0;
    logic [W-1:0] exp_mat [M][N];
    beat_t     sb[$];
    beat_t     mon_b, hold_b;
    logic      stall_q = 1'b0;

    matrix_slice_streamer #(.M(M), .N(N), .nBits(W), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .matrix_in(matrix_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_i(req_i), .req_j(req_j),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_i(out_i), .out_j(out_j), .out_last(out_last),
`ifdef SEL_BOUNDS_CHECK_EN
        .err(err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input int i, input int j);
        if (i < M && j < N) return exp_mat[i][j];
        return '0;
    endfunction

    function automatic bit is_oob(input logic [1:0] mode, input int i, input int j);
        if (mode == 2'd0) return i >= M;
        if (mode == 2'd1) return j >= N;
        return (i >= M) || (j >= N);
    endfunction

    task automatic push_expected(input logic [1:0] mode, input int i, input int j);
        beat_t b;
        if (mode == 2'd0) begin
            for (int c = 0; c < N; c++) begin
                b.d = model(i, c); b.i = IW'(i); b.j = IW'(c); b.last = (c == N - 1);
                sb.push_back(b);
            end
        end else if (mode == 2'd1) begin
            for (int r = 0; r < M; r++) begin
                b.d = model(r, j); b.i = IW'(r); b.j = IW'(j); b.last = (r == M - 1);
                sb.push_back(b);
            end
        end else begin
            b.d = model(i, j); b.i = IW'(i); b.j = IW'(j); b.last = 1'b1;
            sb.push_back(b);
        end
    endtask

    task automatic load_matrix(input int base);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) begin
                exp_mat[r][c] = W'(base + 16 * r + c);
                matrix_in[W*(M*N-N*r-c)-1 -: W] = exp_mat[r][c];
            end
    endtask

    task automatic do_req(input logic [1:0] mode, input int i, input int j, input bit pre, input bit drain);
        int n = 0;
        bit oob = 1'b0;
        if (!pre) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_mode = mode; req_i = IW'(i); req_j = IW'(j);
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check("req_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
`ifdef SEL_BOUNDS_CHECK_EN
        oob = is_oob(mode, i, j);
`endif
        if (!oob) push_expected(mode, i, j);
        @(posedge clk); #1;
        req_valid = 1'b0; req_i = 8'hAA; req_j = 8'h55; req_mode = 2'd1;
        @(negedge clk);
`ifdef SEL_BOUNDS_CHECK_EN
        if (oob) begin
            check("oob_no_valid", out_valid, 0);
            check("oob_err", err, 1);
            check("oob_busy", busy, 0);
            @(negedge clk);
            check("oob_err_pulse", err, 0);
            check("oob_no_valid2", out_valid, 0);
            return;
        end
`endif
        check("first_beat_valid", out_valid, 1);
        check("busy_streaming", busy, 1);
        if (drain) begin
            n = 0;
            while ((sb.size() != 0 || busy) && n < 200) begin @(negedge clk); n++; end
            check("drain", sb.size(), 0);
            check("idle_after", busy, 0);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && out_valid) begin
                check("hold_data", out_data, hold_b.d);
                check("hold_i", out_i, hold_b.i);
                check("hold_j", out_j, hold_b.j);
                check("hold_last", out_last, hold_b.last);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    mon_b = sb.pop_front();
                    check("beat_data", out_data, mon_b.d);
                    check("beat_i", out_i, mon_b.i);
                    check("beat_j", out_j, mon_b.j);
                    check("beat_last", out_last, mon_b.last);
                end
            end
            stall_q = out_valid && !out_ready;
            hold_b.d = out_data; hold_b.i = out_i; hold_b.j = out_j; hold_b.last = out_last;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_load_ready", load_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);

        @(posedge clk); #1;
        load_matrix(0);
        load_valid = 1'b1;
        @(negedge clk);
        check("load_ready", load_ready, 1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        @(negedge clk);
        check("req_ready_loaded", req_ready, 1);

        rdy_mode = 0;
        do_req(2'd0, 2, 0, 1'b0, 1'b1);

        rdy_mode = 1;
        do_req(2'd1, 0, 3, 1'b0, 1'b1);

        rdy_mode = 0;
        do_req(2'd2, 1, 2, 1'b0, 1'b1);
        check("elem_req_ready_back", req_ready, 1);

        @(posedge clk); #1;
        load_valid = 1'b1;
        matrix_in = '1;
        req_valid = 1'b1; req_mode = 2'd0; req_i = 8'd1; req_j = 8'd0;
        load_matrix(32'h100);
        @(negedge clk);
        check("load_wins_req_ready", req_ready, 0);
        check("load_wins_load_ready", load_ready, 1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        do_req(2'd0, 1, 0, 1'b1, 1'b1);

        do_req(2'd0, 5, 0, 1'b0, 1'b1);
        do_req(2'd3, 3, 0, 1'b0, 1'b1);

        rdy_mode = 1;
        do_req(2'd0, 3, 0, 1'b0, 1'b1);

        rdy_mode = 0;
        do_req(2'd0, 2, 0, 1'b0, 1'b0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_load_ready", load_ready, 1);
        repeat (3) @(negedge clk);
        check("mid_rst_no_beats", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
